// File: rtl/debug_bridge.sv
// debug_bridge: JTAG user-op bridge driving NUM_MEM memory channels, CPU halt and a stretched CPU reset.
// Optional macro DEBUG_BRIDGE_AUTOINC_EN: post-increment addr after every acknowledged access.
module debug_bridge #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned NUM_MEM     = 2,
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned RST_STRETCH = 1023
) (
    input  logic                      cpu_clk,
    input  logic                      sys_rstn,
    input  logic                      jtag_userOp_ready,
    input  logic [7:0]                jtag_userOp,
    input  logic [DATA_W-1:0]         jtag_userData,
    output logic [DATA_W-1:0]         cpu_userData,
    output logic [NUM_MEM-1:0]        mem_req,
    output logic [NUM_MEM-1:0]        mem_we,
    output logic [NUM_MEM*ADDR_W-1:0] mem_addr,
    output logic [NUM_MEM*DATA_W-1:0] mem_wdata,
    input  logic [NUM_MEM*DATA_W-1:0] mem_rdata,
    input  logic [NUM_MEM-1:0]        mem_ack,
    output logic                      cpu_halt_cpu,
    output logic                      cpu_resetn_cpu,
    output logic                      dbg_busy
);
    localparam int unsigned SEL_W = (NUM_MEM > 1) ? $clog2(NUM_MEM) : 1;
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned RS_W  = $clog2(RST_STRETCH + 1);

    localparam logic [7:0] OP_HALT   = 8'h01;
    localparam logic [7:0] OP_UNHALT = 8'h02;
    localparam logic [7:0] OP_RESET  = 8'h03;
    localparam logic [7:0] OP_READ   = 8'h04;
    localparam logic [7:0] OP_WRITE  = 8'h05;
    localparam logic [7:0] OP_SEL    = 8'h80;
    localparam logic [7:0] OP_ADDR   = 8'h81;
    localparam logic [7:0] OP_WDATA  = 8'h82;
    localparam logic [7:0] OP_STATUS = 8'h84;

    typedef enum logic {IDLE, ACCESS} state_t;
    state_t state, state_nxt;

    logic [1:0]        sync_q;
    logic              sync_prev;
    logic              exec;
    logic [SEL_W-1:0]  sel;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              acc_we;
    logic              we_nxt;
    logic [TO_W-1:0]   to_cnt;
    logic [RS_W-1:0]   stretch;
    logic [RS_W-1:0]   stretch_nxt;
    logic              err_sel, err_ovr, err_to;
    logic              ack_sel;
    logic [DATA_W-1:0] rdata_sel;
    logic [NUM_MEM-1:0] sel_vec;
    logic              sel_valid;
    logic              start, done, set_to, set_ovr, set_sel, clr_flags;
    logic [DATA_W-1:0] status;

    assign exec      = sync_q[1] & ~sync_prev;
    assign sel_valid = 32'(jtag_userData[2:0]) < NUM_MEM;
    assign status    = DATA_W'({err_sel, err_ovr, err_to, cpu_halt_cpu, dbg_busy});
    assign mem_addr  = {NUM_MEM{addr}};
    assign mem_wdata = {NUM_MEM{wdata}};

    // Selected-channel view of the per-channel buses
    always_comb begin
        ack_sel   = 1'b0;
        rdata_sel = '0;
        sel_vec   = '0;
        for (int unsigned i = 0; i < NUM_MEM; i++) begin
            if (SEL_W'(i) == sel) begin
                ack_sel    = mem_ack[i];
                rdata_sel  = mem_rdata[i*DATA_W +: DATA_W];
                sel_vec[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge cpu_clk or negedge sys_rstn) begin
        if (!sys_rstn) state <= IDLE;
        else           state <= state_nxt;
    end

    // Next state plus per-edge event decode; a reset op beats an ack in the same cycle
    always_comb begin
        state_nxt   = state;
        start       = 1'b0;
        done        = 1'b0;
        set_to      = 1'b0;
        set_ovr     = 1'b0;
        set_sel     = 1'b0;
        clr_flags   = exec && (jtag_userOp == OP_STATUS);
        stretch_nxt = stretch;
        case (state)
            IDLE: begin
                if (exec && (jtag_userOp == OP_READ || jtag_userOp == OP_WRITE)) begin
                    state_nxt = ACCESS;
                    start     = 1'b1;
                end
                if (exec && jtag_userOp == OP_SEL && !sel_valid) set_sel = 1'b1;
            end
            ACCESS: begin
                if (exec && jtag_userOp == OP_RESET) begin
                    state_nxt = IDLE;
                end else if (ack_sel) begin
                    state_nxt = IDLE;
                    done      = 1'b1;
                end else if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                    state_nxt = IDLE;
                    set_to    = 1'b1;
                end
                if (exec && (jtag_userOp inside {OP_READ, OP_WRITE, OP_SEL, OP_ADDR, OP_WDATA}))
                    set_ovr = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
        we_nxt = start ? (jtag_userOp == OP_WRITE) : acc_we;
        if (exec && jtag_userOp == OP_RESET) stretch_nxt = RS_W'(RST_STRETCH);
        else if (stretch != '0)              stretch_nxt = stretch - RS_W'(1);
    end

    always_ff @(posedge cpu_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            sync_q         <= '0;
            sync_prev      <= 1'b0;
            acc_we         <= 1'b0;
            to_cnt         <= '0;
            mem_req        <= '0;
            mem_we         <= '0;
            dbg_busy       <= 1'b0;
            stretch        <= '0;
            cpu_resetn_cpu <= 1'b1;
            cpu_halt_cpu   <= 1'b0;
            sel            <= '0;
            addr           <= '0;
            wdata          <= '0;
            cpu_userData   <= '0;
            err_sel        <= 1'b0;
            err_ovr        <= 1'b0;
            err_to         <= 1'b0;
        end else begin
            sync_q         <= {sync_q[0], jtag_userOp_ready};
            sync_prev      <= sync_q[1];
            acc_we         <= we_nxt;
            to_cnt         <= (state == ACCESS) ? to_cnt + TO_W'(1) : '0;
            mem_req        <= (state_nxt == ACCESS) ? sel_vec : '0;
            mem_we         <= (state_nxt == ACCESS && we_nxt) ? sel_vec : '0;
            dbg_busy       <= (state_nxt == ACCESS);
            stretch        <= stretch_nxt;
            cpu_resetn_cpu <= (stretch_nxt == '0);
            if (exec) begin
                case (jtag_userOp)
                    OP_HALT:             cpu_halt_cpu <= 1'b1;
                    OP_UNHALT, OP_RESET: cpu_halt_cpu <= 1'b0;
                    default: ;
                endcase
            end
            // Register loads are only honoured while no access is outstanding
            if (exec && state == IDLE) begin
                case (jtag_userOp)
                    OP_SEL:   if (sel_valid) sel <= SEL_W'(jtag_userData[2:0]);
                    OP_ADDR:  addr  <= jtag_userData[ADDR_W-1:0];
                    OP_WDATA: wdata <= jtag_userData;
                    default: ;
                endcase
            end
`ifdef DEBUG_BRIDGE_AUTOINC_EN
            if (done) addr <= addr + ADDR_W'(1);
`endif
            if (done && !acc_we) cpu_userData <= rdata_sel;
            else if (clr_flags)  cpu_userData <= status;
            err_sel <= (err_sel & ~clr_flags) | set_sel;
            err_ovr <= (err_ovr & ~clr_flags) | set_ovr;
            err_to  <= (err_to  & ~clr_flags) | set_to;
        end
    end
endmodule

// File: tb/tb_debug_bridge.sv
// tb_debug_bridge: directed vectors against a transaction-level model of debug_bridge, checked every cycle.
module tb_debug_bridge;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned NM = 2;
    localparam int unsigned TO = 4;
    localparam int unsigned RS = 8;
`ifdef DEBUG_BRIDGE_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic             cpu_clk = 1'b0;
    logic             sys_rstn = 1'b1;
    logic             jtag_userOp_ready = 1'b0;
    logic [7:0]       jtag_userOp = 8'h00;
    logic [DW-1:0]    jtag_userData = '0;
    logic [DW-1:0]    cpu_userData;
    logic [NM-1:0]    mem_req;
    logic [NM-1:0]    mem_we;
    logic [NM*AW-1:0] mem_addr;
    logic [NM*DW-1:0] mem_wdata;
    logic [NM*DW-1:0] mem_rdata;
    logic [NM-1:0]    mem_ack = '0;
    logic             cpu_halt_cpu;
    logic             cpu_resetn_cpu;
    logic             dbg_busy;

    debug_bridge #(.DATA_W(DW), .ADDR_W(AW), .NUM_MEM(NM), .TIMEOUT_CYC(TO), .RST_STRETCH(RS)) dut (
        .cpu_clk(cpu_clk), .sys_rstn(sys_rstn),
        .jtag_userOp_ready(jtag_userOp_ready), .jtag_userOp(jtag_userOp), .jtag_userData(jtag_userData),
        .cpu_userData(cpu_userData), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .cpu_halt_cpu(cpu_halt_cpu), .cpu_resetn_cpu(cpu_resetn_cpu), .dbg_busy(dbg_busy)
    );

    always #5 cpu_clk = ~cpu_clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Memory responder: ack in the lat-th request cycle (0 = never); stray drives acks on idle channels
    int            lat [NM];
    logic [DW-1:0] rd [NM];
    logic          stray = 1'b0;
    int            req_cnt [NM];
    int            we_cnt [NM];
    int            rst_lo_cnt = 0;
    int            acc_cnt [NM];

    assign mem_rdata = {rd[1], rd[0]};

    initial begin
        for (int c = 0; c < NM; c++) begin
            lat[c] = 0; rd[c] = '0; req_cnt[c] = 0; we_cnt[c] = 0; acc_cnt[c] = 0;
        end
        forever begin
            @(negedge cpu_clk);
            if (!cpu_resetn_cpu) rst_lo_cnt++;
            for (int c = 0; c < NM; c++) begin
                if (mem_req[c]) begin
                    req_cnt[c]++;
                    acc_cnt[c]++;
                    mem_ack[c] = (lat[c] != 0) && (acc_cnt[c] == lat[c]);
                end else begin
                    acc_cnt[c] = 0;
                    mem_ack[c] = stray;
                end
                if (mem_we[c]) we_cnt[c]++;
            end
        end
    end

    // Reference model: one op per exec edge, an outstanding access tracked by its age
    logic          m_busy, m_we, m_halt, m_es, m_eo, m_et;
    int            m_sel, m_age, m_str;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_ud;
    logic [2:0]    m_h;

    initial begin : model
        logic ex, clr, s_to, s_ovr, s_sel;
        logic [7:0] op;
        logic [DW-1:0] d, st;
        forever begin
            @(posedge cpu_clk or negedge sys_rstn);
            if (!sys_rstn) begin
                m_busy = 0; m_we = 0; m_halt = 0; m_es = 0; m_eo = 0; m_et = 0;
                m_sel = 0; m_age = 0; m_str = 0; m_addr = '0; m_wdata = '0; m_ud = '0; m_h = '0;
            end else begin
                ex  = m_h[1] && !m_h[2];
                m_h = {m_h[1:0], jtag_userOp_ready};
                op  = jtag_userOp;
                d   = jtag_userData;
                st  = DW'({m_es, m_eo, m_et, m_halt, m_busy});
                clr = ex && op == 8'h84;
                s_to = 0; s_ovr = 0; s_sel = 0;
                if (clr) m_ud = st;
                if (m_busy) begin
                    m_age++;
                    if (ex && op == 8'h03) m_busy = 0;
                    else if (mem_ack[m_sel]) begin
                        m_busy = 0;
                        if (!m_we) m_ud = mem_rdata[m_sel*DW +: DW];
                        if (AUTOINC) m_addr = m_addr + 1;
                    end else if (m_age >= TO) begin
                        m_busy = 0;
                        s_to = 1;
                    end
                    if (ex && (op inside {8'h04, 8'h05, 8'h80, 8'h81, 8'h82})) s_ovr = 1;
                end else if (ex) begin
                    case (op)
                        8'h04, 8'h05: begin m_busy = 1; m_we = (op == 8'h05); m_age = 0; end
                        8'h80: if (int'(d[2:0]) < NM) m_sel = int'(d[2:0]); else s_sel = 1;
                        8'h81: m_addr = d[AW-1:0];
                        8'h82: m_wdata = d;
                        default: ;
                    endcase
                end
                if (ex && op == 8'h01) m_halt = 1;
                if (ex && (op == 8'h02 || op == 8'h03)) m_halt = 0;
                if (ex && op == 8'h03) m_str = RS;
                else if (m_str > 0) m_str--;
                m_et = (m_et && !clr) || s_to;
                m_eo = (m_eo && !clr) || s_ovr;
                m_es = (m_es && !clr) || s_sel;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model
    initial begin : cmp
        logic [NM-1:0] e_req;
        forever begin
            @(negedge cpu_clk);
            e_req = m_busy ? (NM'(1) << m_sel) : '0;
            check("req", 64'(mem_req), 64'(e_req));
            check("we", 64'(mem_we), m_we ? 64'(e_req) : 64'(0));
            check("busy", 64'(dbg_busy), 64'(m_busy));
            check("halt", 64'(cpu_halt_cpu), 64'(m_halt));
            check("rstn", 64'(cpu_resetn_cpu), 64'(m_str == 0));
            check("addr", mem_addr, {m_addr, m_addr});
            check("wdata", mem_wdata, {m_wdata, m_wdata});
            check("udata", 64'(cpu_userData), 64'(m_ud));
        end
    end

    // Issue one op; must be called at a negedge, returns at the negedge right after its exec edge
    task automatic issue(input logic [7:0] op, input logic [DW-1:0] d);
        jtag_userOp = op;
        jtag_userData = d;
        jtag_userOp_ready = 1'b1;
        @(negedge cpu_clk);
        jtag_userOp_ready = 1'b0;
        @(negedge cpu_clk);
        @(negedge cpu_clk);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge cpu_clk);
    endtask

    task automatic clr_cnt();
        for (int c = 0; c < NM; c++) begin req_cnt[c] = 0; we_cnt[c] = 0; end
        rst_lo_cnt = 0;
    endtask

    initial begin
        #1 sys_rstn = 1'b0;
        @(negedge cpu_clk);
        check("rst_udata", 64'(cpu_userData), 64'h0);
        check("rst_req", 64'(mem_req), 64'h0);
        check("rst_rstn", 64'(cpu_resetn_cpu), 64'h1);
        check("rst_halt", 64'(cpu_halt_cpu), 64'h0);
        sys_rstn = 1'b1;
        wait_cyc(2);

        // Write on channel 1 acked in its third request cycle
        clr_cnt();
        lat[1] = 3;
        issue(8'h80, 32'd1);
        issue(8'h81, 32'h10);
        issue(8'h82, 32'hCAFE);
        issue(8'h05, 32'h0);
        wait_cyc(6);
        check("wr_req1_cycles", 64'(req_cnt[1]), 64'd3);
        check("wr_we1_cycles", 64'(we_cnt[1]), 64'd3);
        check("wr_req0_cycles", 64'(req_cnt[0]), 64'd0);
        check("wr_wdata", mem_wdata, 64'h0000CAFE_0000CAFE);
        check("wr_addr", 64'(mem_addr[31:0]), AUTOINC ? 64'h11 : 64'h10);

        // Read on channel 0 acked after two cycles
        clr_cnt();
        rd[0] = 32'h12345678;
        lat[0] = 2;
        issue(8'h80, 32'd0);
        issue(8'h81, 32'h10);
        issue(8'h04, 32'h0);
        wait_cyc(5);
        check("rd_udata", 64'(cpu_userData), 64'h12345678);
        check("rd_addr", 64'(mem_addr[31:0]), AUTOINC ? 64'h11 : 64'h10);
        check("rd_we0_cycles", 64'(we_cnt[0]), 64'd0);

        // Timeout with acks only on unselected channels
        clr_cnt();
        lat[0] = 0;
        stray = 1'b1;
        issue(8'h04, 32'h0);
        wait_cyc(6);
        stray = 1'b0;
        check("to_req_cycles", 64'(req_cnt[0]), 64'd4);
        check("to_busy", 64'(dbg_busy), 64'h0);
        check("to_udata_kept", 64'(cpu_userData), 64'h12345678);
        check("to_addr_kept", 64'(mem_addr[31:0]), AUTOINC ? 64'h11 : 64'h10);
        issue(8'h84, 32'h0);
        check("to_status", 64'(cpu_userData), 64'h04);
        issue(8'h84, 32'h0);
        check("to_status_clr", 64'(cpu_userData), 64'h00);

        // Status read while an access is outstanding
        issue(8'h04, 32'h0);
        issue(8'h84, 32'h0);
        check("busy_status", 64'(cpu_userData), 64'h01);
        wait_cyc(3);
        issue(8'h84, 32'h0);
        check("busy_status_to", 64'(cpu_userData), 64'h04);

        // Dropped loads during ACCESS and an out-of-range select
        issue(8'h04, 32'h0);
        issue(8'h81, 32'h99);
        wait_cyc(3);
        check("ovr_addr_kept", 64'(mem_addr[31:0]), AUTOINC ? 64'h11 : 64'h10);
        issue(8'h84, 32'h0);
        check("ovr_status", 64'(cpu_userData), 64'h0C);
        issue(8'h80, 32'd5);
        issue(8'h84, 32'h0);
        check("sel_status", 64'(cpu_userData), 64'h10);
        clr_cnt();
        lat[0] = 1;
        issue(8'h04, 32'h0);
        wait_cyc(3);
        check("sel_kept_ch0", 64'(req_cnt[0]), 64'd1);
        check("sel_kept_ch1", 64'(req_cnt[1]), 64'd0);

        // Halt, then reset op aborting an access
        lat[0] = 0;
        issue(8'h01, 32'h0);
        check("halt_set", 64'(cpu_halt_cpu), 64'h1);
        clr_cnt();
        issue(8'h04, 32'h0);
        issue(8'h03, 32'h0);
        check("abort_req", 64'(mem_req), 64'h0);
        check("abort_busy", 64'(dbg_busy), 64'h0);
        check("abort_halt", 64'(cpu_halt_cpu), 64'h0);
        check("abort_rstn", 64'(cpu_resetn_cpu), 64'h0);
        wait_cyc(12);
        check("stretch_len", 64'(rst_lo_cnt), 64'd8);
        check("stretch_end", 64'(cpu_resetn_cpu), 64'h1);
        check("abort_req_cycles", 64'(req_cnt[0]), 64'd3);
        issue(8'h84, 32'h0);
        check("abort_status", 64'(cpu_userData), 64'h00);

        // System reset in the middle of a write
        lat[1] = 0;
        issue(8'h01, 32'h0);
        issue(8'h84, 32'h0);
        check("pre_rst_status", 64'(cpu_userData), 64'h02);
        issue(8'h80, 32'd1);
        issue(8'h05, 32'h0);
        wait_cyc(1);
        check("mid_busy", 64'(dbg_busy), 64'h1);
        check("mid_req", 64'(mem_req), 64'h2);
        #2 sys_rstn = 1'b0;
        #1;
        check("arst_req", 64'(mem_req), 64'h0);
        check("arst_we", 64'(mem_we), 64'h0);
        check("arst_busy", 64'(dbg_busy), 64'h0);
        check("arst_halt", 64'(cpu_halt_cpu), 64'h0);
        check("arst_rstn", 64'(cpu_resetn_cpu), 64'h1);
        check("arst_udata", 64'(cpu_userData), 64'h0);
        check("arst_addr", mem_addr, 64'h0);
        @(negedge cpu_clk);
        sys_rstn = 1'b1;
        wait_cyc(3);
        check("post_rst_req", 64'(mem_req), 64'h0);

        wait_cyc(2);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, required finish before 100000");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/debug_bridge.md
DEBUG_BRIDGE -- requirements
Module: debug_bridge

Interface
REQ-001 Parameters SHALL be: DATA_W, 32, data width; ADDR_W, 32, address width (<= DATA_W); NUM_MEM, 2, memory channel count (1..8); TIMEOUT_CYC, 255, ack timeout in cycles (>= 1); RST_STRETCH, 1023, CPU reset pulse length in cycles (>= 1).
REQ-002 cpu_clk  in  1  sole clock; every register is clocked on its rising edge.
REQ-003 sys_rstn  in  1  asynchronous, active-low reset.
REQ-004 jtag_userOp_ready  in  1  op strobe from the TAP; asynchronous to cpu_clk.
REQ-005 jtag_userOp  in  8  opcode; stable while jtag_userOp_ready is high.
REQ-006 jtag_userData  in  DATA_W  operand; stable while jtag_userOp_ready is high.
REQ-007 cpu_userData  out  DATA_W  readback word to the TAP.
REQ-008 mem_req  out  NUM_MEM  per-channel access request.
REQ-009 mem_we  out  NUM_MEM  per-channel write enable; valid while mem_req is high.
REQ-010 mem_addr  out  NUM_MEM*ADDR_W  shared address register, replicated to every channel.
REQ-011 mem_wdata  out  NUM_MEM*DATA_W  shared write-data register, replicated to every channel.
REQ-012 mem_rdata  in  NUM_MEM*DATA_W  per-channel read data; valid in the mem_ack cycle.
REQ-013 mem_ack  in  NUM_MEM  per-channel access completion.
REQ-014 cpu_halt_cpu  out  1  halt request to the CPU.
REQ-015 cpu_resetn_cpu  out  1  stretched active-low CPU reset.
REQ-016 dbg_busy  out  1  high while an access is outstanding.

Function
REQ-017 jtag_userOp_ready SHALL pass through a 2-flop synchronizer; a rising edge of the synchronized signal SHALL form a one-cycle exec pulse, and jtag_userOp and jtag_userData SHALL be sampled on that pulse.
REQ-018 Ops: 0x00 no-op; 0x01 set halt; 0x02 clear halt; 0x03 clear halt and start reset stretch; 0x04 read; 0x05 write; 0x80 load sel; 0x81 load addr; 0x82 load wdata; 0x84 status to cpu_userData; any other opcode SHALL be ignored.
REQ-019 0x80 SHALL load sel from jtag_userData[2:0] only if the value is < NUM_MEM; otherwise sel SHALL be unchanged and the sticky flag err_sel SHALL be set.
REQ-020 0x81 SHALL load addr from jtag_userData[ADDR_W-1:0].
REQ-021 FSM states SHALL be IDLE and ACCESS: in IDLE, an exec pulse with 0x04 or 0x05 SHALL go to ACCESS; in ACCESS, mem_req[sel] (and mem_we[sel] for 0x05) SHALL be high from the cycle after the exec pulse until the mem_ack[sel] cycle inclusive.
REQ-022 Leaving ACCESS: the mem_ack[sel] cycle SHALL return the FSM to IDLE with mem_req low on the next cycle; a read SHALL capture mem_rdata[sel] into cpu_userData on the ack edge.
REQ-023 mem_ack on a non-selected channel, or while in IDLE, SHALL be ignored.
REQ-024 Timeout: a counter SHALL count ACCESS cycles; reaching TIMEOUT_CYC without ack SHALL abort the access (mem_req low next cycle, FSM to IDLE), set sticky err_to and leave cpu_userData unchanged.
REQ-025 dbg_busy SHALL be 1 exactly while the FSM is in ACCESS.
REQ-026 Exec pulses in ACCESS for 0x04, 0x05, 0x80, 0x81 or 0x82 SHALL be dropped and SHALL set sticky err_ovr.
REQ-027 Exec pulses in ACCESS for 0x00, 0x01, 0x02 or 0x84 SHALL execute normally.
REQ-028 Exec 0x03 in ACCESS SHALL abort the access (as REQ-024, without setting err_to) and start the reset stretch.
REQ-029 Status word SHALL be {zero-fill, err_sel, err_ovr, err_to, cpu_halt_cpu, dbg_busy}, LSB = dbg_busy; 0x84 SHALL load it into cpu_userData and clear all three sticky flags in the same edge.
REQ-030 A sticky-flag set coinciding with the 0x84 clear SHALL win, leaving the flag set.
REQ-031 Reset stretch: 0x03 SHALL load the stretch counter with RST_STRETCH, which then decrements to 0; cpu_resetn_cpu SHALL be low while the counter is nonzero; a repeated 0x03 SHALL reload the counter.

Reset
REQ-032 On sys_rstn low, asynchronously: FSM = IDLE; mem_req, mem_we, cpu_halt_cpu, dbg_busy, sel, addr, wdata, cpu_userData, sticky flags, synchronizer and stretch counter = 0; cpu_resetn_cpu = 1.
REQ-033 Reset asserted mid-access SHALL drop mem_req immediately; no read data SHALL be captured.

Configuration
REQ-034 Macro DEBUG_BRIDGE_AUTOINC_EN: when defined, every completed (acked) read or write SHALL increment addr by 1, modulo 2^ADDR_W; a timed-out or aborted access SHALL leave addr unchanged.
REQ-035 When DEBUG_BRIDGE_AUTOINC_EN is undefined, addr SHALL change only on 0x81.

Verification
REQ-036 NUM_MEM=2: 0x80 data 1, 0x81 data 0x10, 0x82 data 0xCAFE, 0x05 with ack after 3 cycles -> mem_req[1]/mem_we[1] high for 3 cycles, mem_wdata=0xCAFE, mem_req[0] never high.
REQ-037 0x04 on channel 0, ack with mem_rdata[0]=0x12345678 -> cpu_userData=0x12345678; with AUTOINC, addr 0x10 -> 0x11; without, addr stays 0x10.
REQ-038 TIMEOUT_CYC=4, 0x04 with ack never asserted -> mem_req high 4 cycles then low, dbg_busy low, 0x84 returns 0x04, a second 0x84 returns 0x00.
REQ-039 0x81 issued during ACCESS -> addr unchanged, err_ovr set; 0x80 data 5 with NUM_MEM=2 -> sel unchanged, status bit 4 set.
REQ-040 RST_STRETCH=8, 0x01 then 0x03 mid-access -> mem_req drops, cpu_halt_cpu=0, cpu_resetn_cpu low exactly 8 cycles.
REQ-041 sys_rstn pulsed low during ACCESS -> all outputs at reset values immediately, cpu_resetn_cpu=1.
